// File: rtl/pc_capture_unit_pkg.sv
// Shared widths, reset value and the PC value type for the PC capture unit.
package pc_capture_unit_pkg;

  localparam int          PC_WIDTH       = 32;
  localparam logic [31:0] PC_RESET_VALUE = 32'd0;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_capture_unit_if.sv
// Groups the capture enable, the next-PC input and both registered outputs.
interface pc_capture_unit_if
  import pc_capture_unit_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
);

  logic             en;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] data_out;

  modport master (
    output en,
    output pc_in,
    input  pc_out,
    input  data_out
  );

  modport slave (
    input  en,
    input  pc_in,
    output pc_out,
    output data_out
  );

endinterface

// File: rtl/pc_capture_unit_en_reg.sv
// Register with synchronous reset and load enable; used for both the PC and the snapshot.
module en_reg
  import pc_capture_unit_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (en) begin
      q_next = d;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pc_capture_unit.sv
// PC register followed by an enable-gated holding register that snapshots the current PC.
module pc_capture_unit
  import pc_capture_unit_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input logic              clk,
  input logic              rst,
  pc_capture_unit_if.slave bus
);

  logic [WIDTH-1:0] pc_q;

  // The PC loads every cycle, so its enable is tied high.
  en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_pc_reg (
    .clk  (clk),
    .srst (rst),
    .en   (1'b1),
    .d    (bus.pc_in),
    .q    (pc_q)
  );

  // Snapshot takes the pre-edge PC, giving two cycles from pc_in to data_out.
  en_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_hold_reg (
    .clk  (clk),
    .srst (rst),
    .en   (bus.en),
    .d    (pc_q),
    .q    (bus.data_out)
  );

  assign bus.pc_out = pc_q;

endmodule

// File: tb/tb_pc_capture_unit.sv
// Directed plan plus randomized traffic, checked against a two-value reference model.
module tb_pc_capture_unit;
  import pc_capture_unit_pkg::*;

  localparam pc_t RV = pc_t'(PC_RESET_VALUE);

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  pc_t  exp_pc;
  pc_t  exp_data;

  always #5 clk = ~clk;

  pc_capture_unit_if #(.WIDTH(PC_WIDTH)) bus ();

  pc_capture_unit #(
    .WIDTH       (PC_WIDTH),
    .RESET_VALUE (RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input pc_t got, input pc_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock edge: drive inputs, advance the model, then sample 1ns after the edge.
  task automatic cycle(input logic r, input logic e, input pc_t p, input string tag);
    rst       = r;
    bus.en    = e;
    bus.pc_in = p;
    @(posedge clk);
    if (r) begin
      exp_pc   = RV;
      exp_data = RV;
    end else begin
      if (e) exp_data = exp_pc;
      exp_pc = p;
    end
    #1;
    $display("txn %s rst=%0b en=%0b pc_in=%0d pc_out=%0d data_out=%0d",
             tag, r, e, p, bus.pc_out, bus.data_out);
    check_val({tag, ".pc_out"},   bus.pc_out,   exp_pc);
    check_val({tag, ".data_out"}, bus.data_out, exp_data);
  endtask

  initial begin
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.pc_in = pc_t'(5);

    // Power-on reset
    cycle(1'b1, 1'b0, pc_t'(5), "por0");
    cycle(1'b1, 1'b0, pc_t'(5), "por1");
    check_val("por.abs", bus.data_out, pc_t'(0));

    // Release reset, then enable capture
    cycle(1'b0, 1'b0, pc_t'(15), "rel0");
    cycle(1'b0, 1'b1, pc_t'(15), "rel1");
    check_val("rel.abs", bus.data_out, pc_t'(15));

    // Streaming with enable held high
    cycle(1'b0, 1'b1, pc_t'(25), "str0");
    cycle(1'b0, 1'b1, pc_t'(35), "str1");
    cycle(1'b0, 1'b1, pc_t'(45), "str2");
    cycle(1'b0, 1'b1, pc_t'(55), "str3");
    cycle(1'b0, 1'b1, pc_t'(55), "str4");
    check_val("str.abs", bus.data_out, pc_t'(55));

    // Enable gating
    cycle(1'b0, 1'b0, pc_t'(65), "gate0");
    cycle(1'b0, 1'b0, pc_t'(15), "gate1");
    cycle(1'b0, 1'b1, pc_t'(15), "gate2");
    cycle(1'b0, 1'b1, pc_t'(25), "gate3");
    cycle(1'b0, 1'b0, pc_t'(25), "gate4");
    check_val("gate.abs", bus.data_out, pc_t'(15));

    // Mid-run reset with en=1, then resume
    cycle(1'b1, 1'b1, pc_t'(65), "mrst0");
    cycle(1'b0, 1'b1, pc_t'(35), "mrst1");
    check_val("mrst.first_capture", bus.data_out, RV);
    cycle(1'b0, 1'b1, pc_t'(35), "mrst2");
    check_val("mrst.abs", bus.data_out, pc_t'(35));

    // Reset pulse between edges must not disturb the outputs
    #1;
    rst = 1'b1;
    #2;
    check_val("async.pc_out",   bus.pc_out,   exp_pc);
    check_val("async.data_out", bus.data_out, exp_data);
    rst = 1'b0;
    cycle(1'b0, 1'b0, pc_t'(45), "async1");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), pc_t'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
